// File: rtl/snake_dir_ctrl_if.sv
// snake_dir_ctrl_if
//   Bundles the raw push-buttons and game-step pulse driven into the snake
//   direction controller, together with the registered direction, turn,
//   rejected and queue-occupancy outputs it returns.
//
//   master : the game / board side (drives buttons and step)
//   slave  : snake_dir_ctrl (drives direction, turn, rejected, queue_count)
//
//   up, down, left, right : raw asynchronous buttons, active-high
//   step                  : one-cycle game-tick pulse
//   direction[5:0]        : committed one-hot direction
//   turn                  : one-cycle pulse when direction changes on a step
//   rejected              : one-cycle pulse when a press is discarded
//   queue_count           : number of pending turns
interface snake_dir_ctrl_if #(
  parameter int QUEUE_DEPTH = 2
) ();
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic          up;
  logic          down;
  logic          left;
  logic          right;
  logic          step;
  logic [5:0]    direction;
  logic          turn;
  logic          rejected;
  logic [CW-1:0] queue_count;

  modport master (
    output up, down, left, right, step,
    input  direction, turn, rejected, queue_count
  );

  modport slave (
    input  up, down, left, right, step,
    output direction, turn, rejected, queue_count
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
//   Direction-input controller for the snake game. Each raw button is
//   synchronised (2 flops), debounced and edge-detected. Accepted presses are
//   compared with the most recent committed or queued direction; legal turns
//   wait in a small circular queue and one turn is committed per game step.
//
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : snake_dir_ctrl_if.slave
//           in  up/down/left/right (raw), step
//           out direction (one-hot 000001 L, 000010 R, 000100 U, 001000 D),
//               turn, rejected, queue_count
//
//   Button vector bit order matches the direction code bit order:
//   bit 0 left, bit 1 right, bit 2 up, bit 3 down.
module snake_dir_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         QUEUE_DEPTH     = 2,
  parameter logic [5:0] INIT_DIR        = 6'b000010
) (
  input logic             clk,
  input logic             rst_n,
  snake_dir_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(QUEUE_DEPTH);

  // ---------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------
  logic [3:0]    raw;

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    stable_prev_q, stable_prev_d;
  logic [3:0]    press_q, press_d;
  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];

  logic [5:0]    fifo_q [QUEUE_DEPTH];
  logic [5:0]    fifo_d [QUEUE_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [5:0]    dir_q, dir_d;
  logic          turn_q, turn_d;
  logic          rejected_q, rejected_d;

  logic [3:0]    rise;
  logic [PW-1:0] tail_last;
  logic [5:0]    ref_dir;
  logic [5:0]    opp_dir;
  logic [5:0]    press_dir;
  logic          pop;
  logic          push;
  logic          reject;

  assign raw = {bus.down, bus.up, bus.right, bus.left};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  // ---------------------------------------------------------------------
  // Debounce: the stable level only follows the synchronised level after
  // DEBOUNCE_CYCLES consecutive samples that disagree with it. The toggle
  // happens on the edge where the count would reach DEBOUNCE_CYCLES.
  // ---------------------------------------------------------------------
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Press detection: rising edge of the stable level. Registering the
  // selected press keeps the queue logic off the debounce path; only one
  // press per cycle survives, priority left > right > up > down.
  // ---------------------------------------------------------------------
  always_comb begin
    stable_prev_d = stable_q;
    rise          = stable_q & ~stable_prev_q;
    press_d       = 4'b0000;
    if (rise[0]) begin
      press_d = 4'b0001;
    end else if (rise[1]) begin
      press_d = 4'b0010;
    end else if (rise[2]) begin
      press_d = 4'b0100;
    end else if (rise[3]) begin
      press_d = 4'b1000;
    end
  end

  // ---------------------------------------------------------------------
  // Turn queue and committed direction
  // ---------------------------------------------------------------------
  always_comb begin
    tail_last = (tail_q == '0) ? PTR_LAST : tail_q - PW'(1);

    // A new press is judged against where the snake will be heading once
    // everything already queued has been applied.
    ref_dir   = (count_q != '0) ? fifo_q[tail_last] : dir_q;
    opp_dir   = {2'b00, ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};
    press_dir = {2'b00, press_q};

    pop    = bus.step && (count_q != '0);
    push   = 1'b0;
    reject = 1'b0;

    if (press_q != 4'b0000) begin
      if (press_dir == ref_dir) begin
        push   = 1'b0;
      end else if (press_dir == opp_dir) begin
        reject = 1'b1;
      end else if ((count_q == CNT_FULL) && !pop) begin
        reject = 1'b1;
      end else begin
        push   = 1'b1;
      end
    end

    fifo_d = fifo_q;
    head_d = head_q;
    tail_d = tail_q;
    dir_d  = dir_q;

    if (pop) begin
      dir_d  = fifo_q[head_q];
      head_d = ptr_inc(head_q);
    end

    // When full, a same-cycle pop frees the head slot, which is the slot
    // the tail pointer is sitting on, so the write cannot clobber the entry
    // being popped (that entry is read from the old array).
    if (push) begin
      fifo_d[tail_q] = press_dir;
      tail_d         = ptr_inc(tail_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    turn_d     = pop;
    rejected_d = reject;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      press_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      dir_q         <= INIT_DIR;
      turn_q        <= 1'b0;
      rejected_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      press_q       <= press_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      dir_q         <= dir_d;
      turn_q        <= turn_d;
      rejected_q    <= rejected_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs (all straight from flops)
  // ---------------------------------------------------------------------
  assign bus.direction   = dir_q;
  assign bus.turn        = turn_q;
  assign bus.rejected    = rejected_q;
  assign bus.queue_count = count_q;

endmodule
